// File: rtl/online_pkg.sv
// rtl/online_pkg.sv - signed-digit encodings and converter state encoding shared by the online datapath
package online_pkg;

    // Radix-2 signed digit {p,n}; value = p - n. 2'b11 is a redundant zero.
    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } otf_state_t;

endpackage

// File: rtl/online_otf_converter_otf_step.sv
// rtl/online_otf_converter_otf_step.sv - one combinational Q/QM on-the-fly conversion step
//  W        : register width (>= 2)
//  q, qm    : current conversion pair, qm == q - 1
//  d        : signed digit {p,n}
//  q_next   : q after appending d (shift left, upper bit discarded)
//  qm_next  : q_next - 1
module otf_step
    import online_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   d,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next
);

    always_comb begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
        case (d)
            DIG_POS: begin
                q_next  = {q[W-2:0], 1'b1};
                qm_next = {q[W-2:0], 1'b0};
            end
            DIG_NEG: begin
                // Borrow taken from QM, so no carry propagation is ever needed.
                q_next  = {qm[W-2:0], 1'b1};
                qm_next = {qm[W-2:0], 1'b0};
            end
            default: begin
                // DIG_ZERO and the redundant 2'b11 both mean zero.
                q_next  = {q[W-2:0], 1'b0};
                qm_next = {qm[W-2:0], 1'b1};
            end
        endcase
    end

endmodule

// File: rtl/online_otf_converter.sv
// rtl/online_otf_converter.sv - MSD-first signed-digit stream to two's-complement word converter
//  NDIG       : digits per word; out_data is NDIG+1 bits
//  clk        : clock, rising edge
//  rst_n      : synchronous active-low reset
//  in_valid   : in_digit/in_sof valid
//  in_ready   : digit accepted this cycle when in_valid is also high
//  in_digit   : signed digit {p,n}
//  in_sof     : digit is the MSD of a new word (drops any partial word)
//  out_valid  : out_data holds a completed word
//  out_ready  : downstream consumes out_data
//  out_data   : sum d_i * 2^(NDIG-i), i = 1..NDIG
//  err        : only with OTF_DIGIT_CHECK_EN; sticky flag for 2'b11 digits or
//               in_sof arriving mid-word, cleared only by reset
module online_otf_converter
    import online_pkg::*;
#(
    parameter int NDIG = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_digit,
    input  logic          in_sof,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NDIG:0] out_data
`ifdef OTF_DIGIT_CHECK_EN
    ,
    output logic          err
`endif
);

    localparam int W  = NDIG + 1;
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    otf_state_t    state_r;
    otf_state_t    state_nxt;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  q_r;
    logic [W-1:0]  qm_r;

    logic          accept;
    logic [W-1:0]  base_q;
    logic [W-1:0]  base_qm;
    logic [CW-1:0] eff_cnt;
    logic          word_done;
    logic [W-1:0]  q_step;
    logic [W-1:0]  qm_step;

    assign accept = in_valid && in_ready;

    // A start-of-frame digit restarts conversion from the empty pair
    // regardless of how far the current word has progressed.
    assign base_q    = in_sof ? '0 : q_r;
    assign base_qm   = in_sof ? '1 : qm_r;
    assign eff_cnt   = in_sof ? '0 : cnt_r;
    assign word_done = accept && (eff_cnt == LAST_CNT);

    otf_step #(
        .W (W)
    ) u_step (
        .q       (base_q),
        .qm      (base_qm),
        .d       (in_digit),
        .q_next  (q_step),
        .qm_next (qm_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ACC;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ACC:     if (word_done) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ACC:     in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            q_r      <= '0;
            qm_r     <= '1;
            out_data <= '0;
        end else if (accept) begin
            if (word_done) begin
                out_data <= q_step;
                cnt_r    <= '0;
            end else begin
                q_r   <= q_step;
                qm_r  <= qm_step;
                cnt_r <= eff_cnt + CW'(1);
            end
        end else if (state_r == HOLD && out_ready) begin
            q_r  <= '0;
            qm_r <= '1;
        end
    end

`ifdef OTF_DIGIT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept && ((in_digit == 2'b11) || (in_sof && cnt_r != '0))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_online_otf_converter.sv
// tb/tb_online_otf_converter.sv - directed self-checking bench for online_otf_converter (NDIG=11)
module tb_online_otf_converter;

    localparam int NDIG = 11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_digit;
    logic            in_sof;
    logic            out_valid;
    logic            out_ready;
    logic [NDIG:0]   out_data;
`ifdef OTF_DIGIT_CHECK_EN
    logic            err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    online_otf_converter #(
        .NDIG (NDIG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef OTF_DIGIT_CHECK_EN
        ,
        .err       (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one digit and return #1 after the edge that accepted it.
    task automatic feed(input logic [1:0] d, input logic s);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_digit = d;
        in_sof   = s;
        while (!in_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) check("feed_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Eleven digits packed MSD in bits [21:20]; checks 1-cycle latency and the result.
    task automatic send_word(input string tag, input logic [21:0] digs, input logic sof0,
                             input logic [NDIG:0] exp);
        logic [21:0] w;
        w = digs;
        for (int i = 0; i < NDIG; i++) begin
            if (i == NDIG - 1) check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
            feed(w[21:20], (i == 0) ? sof0 : 1'b0);
            w = w << 2;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_digit = 2'b00;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [21:0] all_pos;
        logic [21:0] all_neg;
        logic [21:0] pn_zeros;
        logic [21:0] zp_zeros;
        logic [21:0] mixed;
        logic [21:0] neg_mixed;
        logic [21:0] red_zero;

        all_pos   = {11{2'b10}};
        all_neg   = {11{2'b01}};
        pn_zeros  = {2'b10, 2'b01, {9{2'b00}}};
        zp_zeros  = {2'b00, 2'b10, {9{2'b00}}};
        mixed     = {2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        neg_mixed = {2'b01, 2'b10, 2'b10, {8{2'b00}}};
        red_zero  = {2'b11, 2'b10, {9{2'b11}}};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_digit  = 2'b00;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef OTF_DIGIT_CHECK_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back words with in_valid held high.
        send_word("all_pos", all_pos, 1'b1, 12'h7FF);
        send_word("all_neg", all_neg, 1'b0, 12'h801);
        send_word("pn_zeros", pn_zeros, 1'b1, 12'd512);
        send_word("zp_zeros", zp_zeros, 1'b1, 12'd512);
        send_word("mixed", mixed, 1'b0, 12'd785);
        send_word("neg_mixed", neg_mixed, 1'b1, 12'hF00);
        idle();

        // Backpressure: result held while the next digit waits.
        out_ready = 1'b0;
        send_word("bp_word", all_pos, 1'b1, 12'h7FF);
        in_valid = 1'b1;
        in_digit = 2'b10;
        in_sof   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_data_stable", 32'(out_data), 32'h7FF);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        send_word("bp_next", pn_zeros, 1'b1, 12'd512);
        idle();

        // in_sof mid-word discards the partial word.
        for (int i = 0; i < 4; i++) feed(2'b10, 1'b0);
        send_word("sof_restart", all_neg, 1'b1, 12'h801);
`ifdef OTF_DIGIT_CHECK_EN
        check("sof_err", 32'(err), 32'd1);
`endif
        idle();

        // Reset mid-word discards the partial word.
        for (int i = 0; i < 6; i++) feed(2'b10, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("midrst_out_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
`ifdef OTF_DIGIT_CHECK_EN
        check("midrst_err", 32'(err), 32'd0);
`endif
        send_word("after_rst", all_pos, 1'b0, 12'h7FF);
        idle();

        // 2'b11 is a zero digit.
        send_word("red_zero", red_zero, 1'b0, 12'd512);
`ifdef OTF_DIGIT_CHECK_EN
        check("illegal_err", 32'(err), 32'd1);
`endif
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
